// File: rtl/gs_ddram.sv
// rtl/gs_ddram.sv - byte-wide GS RAM port onto 64-bit DDR3 burst interface with one-line read cache
module gs_ddram #(
  parameter logic [28:0] BASE_ADDR = 29'h0600000
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        we,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD, RD_WAIT} state_t;

  state_t      state;
  state_t      state_nx;
  logic        rd_prev;
  logic        we_prev;
  logic [20:0] last_addr;
  logic [63:0] cache_line;
  logic [17:0] cache_tag;
  logic        cache_valid;
  logic        cache_hit;
  logic        new_request;

  // A request is new on a rd/we rising edge or when the client moves to another address.
  assign cache_hit   = cache_valid && (cache_tag == addr[20:3]);
  assign new_request = (state == IDLE) && (rd || we) &&
                       ((rd && !rd_prev) || (we && !we_prev) || (addr != last_addr));
  assign ready          = (state == IDLE) && !new_request;
  assign DDRAM_BURSTCNT = 8'd1;

  // State register.
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: writes take priority, read hits are served without leaving IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (new_request) begin
          if (we)              state_nx = WR_CMD;
          else if (!cache_hit) state_nx = RD_CMD;
        end
      end
      WR_CMD:  if (!DDRAM_BUSY)      state_nx = IDLE;
      RD_CMD:  if (!DDRAM_BUSY)      state_nx = RD_WAIT;
      RD_WAIT: if (DDRAM_DOUT_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command outputs, captured address, read data and the single cache line.
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      rd_prev     <= 1'b0;
      we_prev     <= 1'b0;
      last_addr   <= '0;
      cache_line  <= '0;
      cache_tag   <= '0;
      cache_valid <= 1'b0;
      dout        <= '0;
      DDRAM_RD    <= 1'b0;
      DDRAM_WE    <= 1'b0;
      DDRAM_BE    <= '0;
      DDRAM_DIN   <= '0;
      DDRAM_ADDR  <= BASE_ADDR;
    end else begin
      rd_prev <= rd;
      we_prev <= we;
      case (state)
        IDLE: begin
          if (new_request) begin
            // Capturing on hits too keeps a held read from retriggering.
            last_addr <= addr;
            if (we) begin
              DDRAM_ADDR <= BASE_ADDR + {11'd0, addr[20:3]};
              DDRAM_DIN  <= {8{din}};
              DDRAM_BE   <= 8'd1 << addr[2:0];
              DDRAM_WE   <= 1'b1;
              if (cache_hit) cache_line[{addr[2:0], 3'b000} +: 8] <= din;
            end else if (cache_hit) begin
              dout <= cache_line[{addr[2:0], 3'b000} +: 8];
            end else begin
              DDRAM_ADDR <= BASE_ADDR + {11'd0, addr[20:3]};
              DDRAM_RD   <= 1'b1;
            end
          end
        end
        WR_CMD:  if (!DDRAM_BUSY) DDRAM_WE <= 1'b0;
        RD_CMD:  if (!DDRAM_BUSY) DDRAM_RD <= 1'b0;
        RD_WAIT: begin
          if (DDRAM_DOUT_READY) begin
            cache_line  <= DDRAM_DOUT;
            cache_tag   <= last_addr[20:3];
            cache_valid <= 1'b1;
            dout        <= DDRAM_DOUT[{last_addr[2:0], 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_ddram.sv
// tb/tb_gs_ddram.sv - table-driven self-checking bench for gs_ddram
module tb_gs_ddram;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd, we, ready;
  logic        busy;
  logic [7:0]  burstcnt;
  logic [28:0] ddr_addr;
  logic [63:0] ddr_dout;
  logic        ddr_dout_ready;
  logic        ddr_rd;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_be;
  logic        ddr_we;

  int checks = 0;
  int errors = 0;
  int rd_acc = 0;
  int we_acc = 0;

  always #5 clk = ~clk;

  gs_ddram dut (
    .DDRAM_CLK        (clk),
    .reset            (reset),
    .addr             (addr),
    .din              (din),
    .dout             (dout),
    .rd               (rd),
    .we               (we),
    .ready            (ready),
    .DDRAM_BUSY       (busy),
    .DDRAM_BURSTCNT   (burstcnt),
    .DDRAM_ADDR       (ddr_addr),
    .DDRAM_DOUT       (ddr_dout),
    .DDRAM_DOUT_READY (ddr_dout_ready),
    .DDRAM_RD         (ddr_rd),
    .DDRAM_DIN        (ddr_din),
    .DDRAM_BE         (ddr_be),
    .DDRAM_WE         (ddr_we)
  );

  // Count accepted DDR commands independently of the table.
  always @(posedge clk) begin
    if (!reset && ddr_rd && !busy) rd_acc++;
    if (!reset && ddr_we && !busy) we_acc++;
  end

  typedef struct {
    logic        rd, we;
    logic [20:0] addr;
    logic [7:0]  din;
    logic        busy, dv;
    logic [63:0] dd;
    logic        e_ready, e_rd, e_we;
    logic [7:0]  e_dout;
    logic [28:0] e_addr;
    logic [7:0]  e_be;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic w, input logic [20:0] a,
                              input logic [7:0] d, input logic b, input logic v,
                              input logic [63:0] dd, input logic er, input logic erd,
                              input logic ewe, input logic [7:0] edo,
                              input logic [28:0] ea, input logic [7:0] ebe);
    vec_t x;
    x.rd = r; x.we = w; x.addr = a; x.din = d; x.busy = b; x.dv = v; x.dd = dd;
    x.e_ready = er; x.e_rd = erd; x.e_we = ewe; x.e_dout = edo; x.e_addr = ea; x.e_be = ebe;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [20:0] a, input logic [7:0] d,
                       input logic b, input logic v, input logic [63:0] dd);
    rd = r; we = w; addr = a; din = d; busy = b; ddr_dout_ready = v; ddr_dout = dd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 21'h0, 8'h0, 0, 0, 64'h0);
    tick; tick;
    reset = 1'b0;
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_rd", ddr_rd, 0);
    chk("reset_we", ddr_we, 0);
    chk("reset_dout", dout, 0);
    chk("reset_addr", ddr_addr, 29'h0600000);
    chk("reset_be", ddr_be, 0);
    chk("reset_din", ddr_din, 0);
    chk("burstcnt", burstcnt, 8'd1);
    tick;

    // Write 0x05 = A5 with BUSY high for 3 cycles of WE.
    add(0, 1, 21'h05, 8'hA5, 1, 0, 0, 0, 0, 1, 8'h00, 29'h0600000, 8'h20);
    for (int i = 0; i < 3; i++)
      add(0, 1, 21'h05, 8'hA5, 1, 0, 0, 0, 0, 1, 8'h00, 29'h0600000, 8'h20);
    add(0, 1, 21'h05, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00, 29'h0600000, 8'h20);
    add(0, 1, 21'h05, 8'hA5, 0, 0, 0, 1, 0, 0, 8'h00, 29'h0600000, 8'h20);
    add(0, 0, 21'h05, 8'hA5, 0, 0, 0, 1, 0, 0, 8'h00, 29'h0600000, 8'h20);
    // Read miss at 0x10, data returns after a wait.
    add(1, 0, 21'h10, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 29'h0600002, 8'h20);
    add(1, 0, 21'h10, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 29'h0600002, 8'h20);
    for (int i = 0; i < 9; i++)
      add(1, 0, 21'h10, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 29'h0600002, 8'h20);
    add(1, 0, 21'h10, 8'h00, 0, 1, 64'h8877665544332211, 0, 0, 0, 8'h11, 29'h0600002, 8'h20);
    add(1, 0, 21'h10, 8'h00, 0, 0, 0, 1, 0, 0, 8'h11, 29'h0600002, 8'h20);
    // Read hit at 0x13 via address change.
    add(1, 0, 21'h13, 8'h00, 0, 0, 0, 0, 0, 0, 8'h44, 29'h0600002, 8'h20);
    add(1, 0, 21'h13, 8'h00, 0, 0, 0, 1, 0, 0, 8'h44, 29'h0600002, 8'h20);
    // Write 0x11 = EE into the cached word, then read it back from cache.
    add(0, 1, 21'h11, 8'hEE, 0, 0, 0, 0, 0, 1, 8'h44, 29'h0600002, 8'h02);
    add(0, 1, 21'h11, 8'hEE, 0, 0, 0, 0, 0, 0, 8'h44, 29'h0600002, 8'h02);
    add(1, 0, 21'h11, 8'h00, 0, 0, 0, 0, 0, 0, 8'hEE, 29'h0600002, 8'h02);
    add(1, 0, 21'h11, 8'h00, 0, 0, 0, 1, 0, 0, 8'hEE, 29'h0600002, 8'h02);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rd, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].busy, tbl[i].dv, tbl[i].dd);
      #1;
      chk($sformatf("v%0d_ready", i), ready, tbl[i].e_ready);
      tick;
      chk($sformatf("v%0d_rd", i), ddr_rd, tbl[i].e_rd);
      chk($sformatf("v%0d_we", i), ddr_we, tbl[i].e_we);
      chk($sformatf("v%0d_dout", i), dout, tbl[i].e_dout);
      chk($sformatf("v%0d_addr", i), ddr_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_be", i), ddr_be, tbl[i].e_be);
    end
    chk("write_din", ddr_din, 64'hEEEEEEEEEEEEEEEE);
    chk("rd_accept_count", rd_acc, 1);
    chk("we_accept_count", we_acc, 2);

    // Reset during RD_WAIT, stale DOUT_READY afterwards, then a fresh miss.
    drive(0, 0, 21'h11, 8'h00, 0, 0, 64'h0);
    tick;
    drive(1, 0, 21'h40, 8'h00, 0, 0, 64'h0);
    tick;
    chk("rw_rd_issue", ddr_rd, 1);
    chk("rw_addr", ddr_addr, 29'h0600008);
    tick;
    chk("rw_rd_accepted", ddr_rd, 0);
    #1;
    chk("rw_waiting_ready", ready, 0);
    reset = 1'b1;
    drive(0, 0, 21'h40, 8'h00, 0, 1, 64'hFFFFFFFFFFFFFFFF);
    tick;
    chk("rst_rd", ddr_rd, 0);
    chk("rst_dout", dout, 0);
    reset = 1'b0;
    #1;
    chk("rst_idle_ready", ready, 1);
    tick;
    chk("stale_dv_dout", dout, 0);
    drive(1, 0, 21'h13, 8'h00, 0, 0, 64'h0);
    #1;
    chk("post_rst_ready", ready, 0);
    tick;
    chk("post_rst_rd", ddr_rd, 1);
    chk("post_rst_addr", ddr_addr, 29'h0600002);
    tick;
    drive(1, 0, 21'h13, 8'h00, 0, 1, 64'h0102030405060708);
    tick;
    chk("post_rst_dout", dout, 8'h05);
    chk("final_rd_count", rd_acc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
